// File: rtl/core_c2_exu_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider share one 2*XLEN work register.
// The divider exists only when CORE_C2_MDU_DIV_EN is defined; without it ops 4-7 complete as illegal with a zero result.
module core_c2_exu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mdu_in_valid,
    output logic            mdu_in_ready,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] mdu_rs1_data,
    input  logic [XLEN-1:0] mdu_rs2_data,
    input  logic [4:0]      mdu_rd_idx_i,
    input  logic            mdu_flush,
    output logic            mdu_out_valid,
    input  logic            mdu_out_ready,
    output logic [XLEN-1:0] mdu_rd_data,
    output logic [4:0]      mdu_rd_idx_o,
    output logic            mdu_illegal
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   addend_q, addend_d;
    logic [2*XLEN-1:0] work_q, work_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              special_q, special_d;
    logic              illegal_q, illegal_d;
    logic [4:0]        idx_q, idx_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;

    logic              accept;
    logic              is_div;
    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              special_in, illegal_in;
    logic [XLEN-1:0]   special_res;

    assign accept   = mdu_in_valid && (state_q == IDLE) && !mdu_flush;
    assign is_div   = mdu_op[2];
    assign a_signed = (mdu_op == OP_MULH) || (mdu_op == OP_MULHSU) || (mdu_op == OP_DIV) || (mdu_op == OP_REM);
    assign b_signed = (mdu_op == OP_MULH) || (mdu_op == OP_DIV) || (mdu_op == OP_REM);
    assign a_neg    = a_signed && mdu_rs1_data[XLEN-1];
    assign b_neg    = b_signed && mdu_rs2_data[XLEN-1];
    assign a_abs    = a_neg ? -mdu_rs1_data : mdu_rs1_data;
    assign b_abs    = b_neg ? -mdu_rs2_data : mdu_rs2_data;

`ifdef CORE_C2_MDU_DIV_EN
    logic div_zero, div_ovf;

    assign div_zero   = (mdu_rs2_data == '0);
    assign div_ovf    = a_signed && (mdu_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_rs2_data == '1);
    assign special_in = is_div && (div_zero || div_ovf);
    assign illegal_in = 1'b0;

    // Results that need no iteration are resolved at accept and parked in the work register.
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = mdu_op[1] ? mdu_rs1_data : '1;
        end else if (div_ovf) begin
            special_res = mdu_op[1] ? '0 : mdu_rs1_data;
        end
    end
`else
    assign special_in  = is_div;
    assign illegal_in  = is_div;
    assign special_res = '0;
`endif

    // Multiply step: add the multiplicand into the high half when the current multiplier bit is set, then shift right.
    logic [XLEN:0]     mul_acc;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [2*XLEN-1:0] step_next;
    logic [XLEN-1:0]   result;

    assign mul_acc  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, addend_q} : '0);
    assign mul_next = {mul_acc, work_q[XLEN-1:1]};
    assign prod     = (a_neg_q ^ b_neg_q) ? -work_q : work_q;
    assign mul_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef CORE_C2_MDU_DIV_EN
    // Restoring divide: remainder in the high half, dividend shifting out of / quotient shifting into the low half.
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo_res, rem_res, div_res;

    assign div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, addend_q});
    assign div_diff  = div_shift[XLEN-1:0] - addend_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), work_q[XLEN-2:0], div_ge};
    assign quo_res   = (a_neg_q ^ b_neg_q) ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    assign rem_res   = a_neg_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    assign div_res   = op_q[1] ? rem_res : quo_res;
    assign step_next = op_q[2] ? div_next : mul_next;
    assign result    = op_q[2] ? div_res : mul_res;
`else
    assign step_next = mul_next;
    assign result    = mul_res;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addend_d  = addend_q;
        work_d    = work_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        special_d = special_q;
        illegal_d = illegal_q;
        idx_d     = idx_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = BUSY;
                    cnt_d     = CW'(XLEN);
                    op_d      = mdu_op;
                    idx_d     = mdu_rd_idx_i;
                    a_neg_d   = a_neg;
                    b_neg_d   = b_neg;
                    special_d = special_in;
                    illegal_d = illegal_in;
                    addend_d  = is_div ? b_abs : a_abs;
                    work_d    = special_in ? {{XLEN{1'b0}}, special_res}
                                           : {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
                end
            end
            BUSY: begin
                // Once the counter is spent, one extra cycle applies sign correction and registers the result.
                if (special_q || (cnt_q == '0)) begin
                    state_d   = DONE;
                    rd_data_d = special_q ? work_q[XLEN-1:0] : result;
                end else begin
                    work_d = step_next;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (mdu_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (mdu_flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            addend_q  <= '0;
            work_q    <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            special_q <= 1'b0;
            illegal_q <= 1'b0;
            idx_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            addend_q  <= addend_d;
            work_q    <= work_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            special_q <= special_d;
            illegal_q <= illegal_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign mdu_in_ready  = (state_q == IDLE);
    assign mdu_out_valid = (state_q == DONE);
    assign mdu_rd_data   = rd_data_q;
    assign mdu_rd_idx_o  = idx_q;
    assign mdu_illegal   = illegal_q;

endmodule

// File: tb/tb_core_c2_exu_mdu.sv
// Bench for core_c2_exu_mdu: directed vector table, handshake/flush/reset sequences, and randomized ops
// checked against a plain-arithmetic RV32M model. Expectations follow CORE_C2_MDU_DIV_EN.
module tb_core_c2_exu_mdu;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            mdu_in_valid, mdu_in_ready;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] mdu_rs1_data, mdu_rs2_data, mdu_rd_data;
    logic [4:0]      mdu_rd_idx_i, mdu_rd_idx_o;
    logic            mdu_flush, mdu_out_valid, mdu_out_ready, mdu_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_c2_exu_mdu #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .mdu_in_valid  (mdu_in_valid),
        .mdu_in_ready  (mdu_in_ready),
        .mdu_op        (mdu_op),
        .mdu_rs1_data  (mdu_rs1_data),
        .mdu_rs2_data  (mdu_rs2_data),
        .mdu_rd_idx_i  (mdu_rd_idx_i),
        .mdu_flush     (mdu_flush),
        .mdu_out_valid (mdu_out_valid),
        .mdu_out_ready (mdu_out_ready),
        .mdu_rd_data   (mdu_rd_data),
        .mdu_rd_idx_o  (mdu_rd_idx_o),
        .mdu_illegal   (mdu_illegal)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics in 64-bit integer arithmetic; bit 32 of the return is the illegal flag.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
`ifndef CORE_C2_MDU_DIV_EN
        if (op[2]) return {1'b1, 32'd0};
`endif
        case (op)
            3'd0: begin p = sa * sb; return {1'b0, p[31:0]}; end
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            3'd4: begin
                if (b == 0) return {1'b0, 32'hFFFF_FFFF};
                if (ovf) return {1'b0, a};
                p = sa / sb;
                return {1'b0, p[31:0]};
            end
            3'd5: begin
                if (b == 0) return {1'b0, 32'hFFFF_FFFF};
                p = ua / ub;
                return {1'b0, p[31:0]};
            end
            3'd6: begin
                if (b == 0) return {1'b0, a};
                if (ovf) return 33'd0;
                p = sa % sb;
                return {1'b0, p[31:0]};
            end
            default: begin
                if (b == 0) return {1'b0, a};
                p = ua % ub;
                return {1'b0, p[31:0]};
            end
        endcase
        return {1'b0, p[63:32]};
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 33;
`ifdef CORE_C2_MDU_DIV_EN
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] idx);
        int t;
        t = 0;
        while (!mdu_in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_before_accept", mdu_in_ready, 1);
        mdu_in_valid = 1'b1;
        mdu_op       = op;
        mdu_rs1_data = a;
        mdu_rs2_data = b;
        mdu_rd_idx_i = idx;
        @(posedge clk); #1;
        // Scramble inputs after accept; the unit must only use what it sampled.
        mdu_in_valid = 1'b0;
        mdu_op       = 3'($urandom);
        mdu_rs1_data = $urandom;
        mdu_rs2_data = $urandom;
        mdu_rd_idx_i = 5'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!mdu_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        mdu_out_ready = 1'b1;
        @(posedge clk); #1;
        mdu_out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] idx);
        logic [32:0] m;
        int          lat;
        m = model(op, a, b);
        start_op(op, a, b, idx);
        wait_valid(lat);
        check({tag, "_data"}, mdu_rd_data, m[31:0]);
        check({tag, "_illegal"}, mdu_illegal, m[32]);
        check({tag, "_idx"}, mdu_rd_idx_o, idx);
        check({tag, "_latency"}, lat, exp_lat(op, a, b));
        drain();
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] exp_d;
        logic        exp_i;
        int          exp_l;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        tbl[1]  = '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 33};
        tbl[5]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        tbl[6]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        tbl[7]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        tbl[8]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        tbl[9]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[10] = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        tbl[11] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[12] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};

        rst = 1'b1;
        mdu_in_valid = 1'b0; mdu_op = '0; mdu_rs1_data = '0; mdu_rs2_data = '0;
        mdu_rd_idx_i = '0; mdu_flush = 1'b0; mdu_out_ready = 1'b0;
        #12;
        check("rst_in_ready", mdu_in_ready, 1);
        check("rst_out_valid", mdu_out_valid, 0);
        check("rst_rd_data", mdu_rd_data, 0);
        check("rst_rd_idx", mdu_rd_idx_o, 0);
        check("rst_illegal", mdu_illegal, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            exp_d = tbl[i].exp;
            exp_i = 1'b0;
            exp_l = tbl[i].lat;
`ifndef CORE_C2_MDU_DIV_EN
            if (tbl[i].op[2]) begin
                exp_d = '0;
                exp_i = 1'b1;
                exp_l = 1;
            end
`endif
            start_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 3));
            wait_valid(lat);
            check($sformatf("vec%0d_data", i), mdu_rd_data, exp_d);
            check($sformatf("vec%0d_illegal", i), mdu_illegal, exp_i);
            check($sformatf("vec%0d_idx", i), mdu_rd_idx_o, 5'(i + 3));
            check($sformatf("vec%0d_latency", i), lat, exp_l);
            drain();
        end

        // DONE holds for 10 cycles with consumer stalled; a request alongside the handshake is not taken.
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_data", mdu_rd_data, 32'hFFFF_FFEB);
            check("hold_idx", mdu_rd_idx_o, 5'd9);
            check("hold_in_ready", mdu_in_ready, 0);
            check("hold_out_valid", mdu_out_valid, 1);
        end
        mdu_in_valid  = 1'b1;
        mdu_out_ready = 1'b1;
        @(posedge clk); #1;
        mdu_in_valid  = 1'b0;
        mdu_out_ready = 1'b0;
        check("release_in_ready", mdu_in_ready, 1);
        check("release_out_valid", mdu_out_valid, 0);

        // Flush at BUSY cycle 5 abandons the op; a request offered with the flush is ignored.
        start_op(3'd5, 32'd1000, 32'd7, 5'd17);
        repeat (4) @(posedge clk);
        #1;
        mdu_flush    = 1'b1;
        mdu_in_valid = 1'b1;
        @(posedge clk); #1;
        mdu_flush    = 1'b0;
        mdu_in_valid = 1'b0;
        check("flush_busy_in_ready", mdu_in_ready, 1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (mdu_out_valid) seen++;
        end
        check("flush_busy_no_result", seen, 0);
        mdu_flush    = 1'b1;
        mdu_in_valid = 1'b1;
        @(posedge clk); #1;
        mdu_flush    = 1'b0;
        mdu_in_valid = 1'b0;
        check("flush_idle_not_accepted", mdu_in_ready, 1);
        run_and_check("after_flush", 3'd7, 32'd1000, 32'd7, 5'd18);

        // Flush in DONE discards the result even though the consumer never took it.
        start_op(3'd3, 32'd12345, 32'd678, 5'd20);
        wait_valid(lat);
        mdu_flush = 1'b1;
        @(posedge clk); #1;
        mdu_flush = 1'b0;
        check("flush_done_out_valid", mdu_out_valid, 0);
        check("flush_done_in_ready", mdu_in_ready, 1);

        // Asynchronous reset mid-BUSY.
        start_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_in_ready", mdu_in_ready, 1);
        check("arst_out_valid", mdu_out_valid, 0);
        check("arst_rd_data", mdu_rd_data, 0);
        check("arst_rd_idx", mdu_rd_idx_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (mdu_out_valid) seen++;
        end
        check("arst_no_result", seen, 0);
        run_and_check("after_arst", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd22);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_and_check($sformatf("rand%0d_op%0d", k, rop), rop, ra, rb, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_c2_exu_mdu.md
CORE_C2_EXU_MDU -- requirements
Module: core_c2_exu_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values are even and >= 8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mdu_in_valid  input  1  request present.
REQ-005 mdu_in_ready  output  1  unit can accept a request.
REQ-006 mdu_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 mdu_rs1_data  input  XLEN  operand A (multiplicand/dividend).
REQ-008 mdu_rs2_data  input  XLEN  operand B (multiplier/divisor).
REQ-009 mdu_rd_idx_i  input  5  destination register tag.
REQ-010 mdu_flush  input  1  abandon any in-flight operation.
REQ-011 mdu_out_valid  output  1  result present.
REQ-012 mdu_out_ready  input  1  consumer accepts the result.
REQ-013 mdu_rd_data  output  XLEN  result.
REQ-014 mdu_rd_idx_o  output  5  tag captured at accept.
REQ-015 mdu_illegal  output  1  accepted op is not supported by this build; qualified by mdu_out_valid.

Function
REQ-016 FSM states are IDLE, BUSY and DONE; mdu_in_ready = (state == IDLE); mdu_out_valid = (state == DONE).
REQ-017 Accept occurs on a clock edge with mdu_in_valid & mdu_in_ready; the edge registers op, operands, tag, operand sign flags and absolute values, and loads the step counter with XLEN.
REQ-018 Multiply: shift-add on unsigned magnitudes, one multiplier bit per BUSY cycle, 2*XLEN-bit product; MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits after sign correction (rs1 signed for MULH and MULHSU; rs2 signed for MULH only).
REQ-019 Divide: restoring division, one quotient bit per BUSY cycle, on magnitudes; quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-020 Normal latency: accept at edge N, XLEN BUSY cycles, mdu_out_valid high after edge N+XLEN+1.
REQ-021 Divisor zero: the unit skips BUSY and enters DONE on the edge after accept; DIV/DIVU return all ones; REM/REMU return rs1.
REQ-022 Signed overflow (DIV/REM with rs1 = 2^(XLEN-1) and rs2 = all ones): the unit skips BUSY; DIV returns rs1 and REM returns 0.
REQ-023 DONE holds mdu_rd_data, mdu_rd_idx_o and mdu_illegal stable until mdu_out_valid & mdu_out_ready, then goes to IDLE; a new request is accepted no earlier than the following edge (no same-cycle back-to-back).
REQ-024 mdu_flush has priority over every other event; at the next edge state goes to IDLE and any result is discarded, including in DONE with mdu_out_ready high; a request presented in the same cycle as mdu_flush is not accepted.
REQ-025 Operand inputs are sampled only at accept; changes while BUSY have no effect.

Reset
REQ-026 While rst is high: state = IDLE, counter = 0, mdu_out_valid = 0, mdu_in_ready = 1, mdu_rd_data = 0, mdu_rd_idx_o = 0, mdu_illegal = 0.
REQ-027 Reset asserted mid-operation aborts the operation immediately, asynchronously to clk; no result is produced.

Configuration
REQ-028 Macro CORE_C2_MDU_DIV_EN defined: all eight ops are implemented as specified above.
REQ-029 Macro CORE_C2_MDU_DIV_EN undefined: divider logic is omitted; ops 4-7 go to DONE on the edge after accept with mdu_rd_data = 0 and mdu_illegal = 1; mul ops are unchanged and mdu_illegal = 0.

Verification
REQ-030 XLEN=32, MUL with rs1=7, rs2=-3 -> mdu_out_valid rises 33 cycles after accept, mdu_rd_data=0xFFFFFFEB; MULH with the same operands -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; for each, mdu_out_valid is high one cycle after accept.
REQ-033 Hold mdu_out_ready low for 10 cycles in DONE -> mdu_rd_data and mdu_rd_idx_o stay stable and mdu_in_ready stays 0; raise mdu_out_ready -> IDLE next edge.
REQ-034 Assert mdu_flush at BUSY cycle 5, and separately assert rst mid-BUSY -> IDLE, mdu_out_valid never asserts for that op, and the next request completes correctly; with CORE_C2_MDU_DIV_EN undefined, DIV -> mdu_illegal = 1 and mdu_rd_data = 0.
